// File: rtl/k_dsp_pkg.sv
// ============================================================================
// Module : k_dsp_pkg
// Brief  : Opcode encoding, default widths and opcode helpers for the K DSP execute stage.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package k_dsp_pkg;

  localparam int K_DATA_W = 32;
  localparam int K_ACC_W  = 40;
  localparam int K_OPC_W  = 4;

  localparam logic [3:0] K_OP_NOP    = 4'd0;
  localparam logic [3:0] K_OP_ADD    = 4'd1;
  localparam logic [3:0] K_OP_SUB    = 4'd2;
  localparam logic [3:0] K_OP_MUL    = 4'd3;
  localparam logic [3:0] K_OP_MAC    = 4'd4;
  localparam logic [3:0] K_OP_MSU    = 4'd5;
  localparam logic [3:0] K_OP_CLRACC = 4'd6;
  localparam logic [3:0] K_OP_RDACC  = 4'd7;

  // Everything above RDACC is reserved.
  function automatic logic k_is_illegal(input logic [31:0] opc);
    return opc > 32'(K_OP_RDACC);
  endfunction

endpackage

`default_nettype wire

// File: rtl/k_dsp_sat.sv
// ============================================================================
// Module : k_dsp_sat
// Brief  : Combinational signed clamp from IN_W to OUT_W bits, with a flag when clamping fired.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module k_dsp_sat #(
  parameter int IN_W  = 34,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  generate
    if (IN_W > OUT_W) begin : g_clamp
      logic w_ovf;
      always_comb begin
        // Representable only if every bit above the target sign bit matches it.
        w_ovf = (din[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){din[IN_W-1]}});
        sat   = w_ovf;
        if (w_ovf) begin
          dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end else begin
          dout = din[OUT_W-1:0];
        end
      end
    end else begin : g_ext
      assign dout = OUT_W'($signed(din));
      assign sat  = 1'b0;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/k_dsp_execute.sv
// ============================================================================
// Module : k_dsp_execute
// Brief  : K DSP execute stage: 2-stage valid/ready ALU/MUL/MAC pipe with private accumulator.
//          Optional saturation enabled by defining K_DSP_SAT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module k_dsp_execute
  import k_dsp_pkg::*;
#(
  parameter int DATA_W = K_DATA_W,
  parameter int ACC_W  = K_ACC_W,
  parameter int OPC_W  = K_OPC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [DATA_W-1:0] rs1,
  input  logic [DATA_W-1:0] rs2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_err,
  output logic              out_sat
);

  // Internal arithmetic width holds any ADD/SUB/MUL/MAC intermediate without loss.
  localparam int W = ((ACC_W > 32) ? ACC_W : 32) + 2;

  logic              s1_valid_q, s1_valid_d;
  logic [OPC_W-1:0]  s1_opc_q, s1_opc_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d;
  logic [DATA_W-1:0] s1_b_q, s1_b_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_result_q, s2_result_d;
  logic              s2_err_q, s2_err_d;
  logic              s2_sat_q, s2_sat_d;
  logic [ACC_W-1:0]  acc_q, acc_d;

  logic w_advance1, w_advance2, w_accept;
  logic w_illegal, w_acc_we, w_res_from_acc;
  logic signed [31:0]  w_prod;
  logic signed [W-1:0] w_a_x, w_b_x, w_p_x, w_acc_x, w_acc_sum, w_res_pre, w_res_src;
  logic [ACC_W-1:0]    w_acc_new;
  logic [DATA_W-1:0]   w_res_val;
  logic                w_res_sat, w_acc_sat, w_sat;

  assign w_advance2 = !s2_valid_q || out_ready;
  assign w_advance1 = s1_valid_q && w_advance2;
  assign in_ready   = !s1_valid_q || w_advance2;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_prod         = $signed(s1_a_q[15:0]) * $signed(s1_b_q[15:0]);
    w_a_x          = W'($signed(s1_a_q));
    w_b_x          = W'($signed(s1_b_q));
    w_p_x          = W'(w_prod);
    w_acc_x        = W'($signed(acc_q));
    w_illegal      = k_is_illegal(32'(s1_opc_q));
    w_acc_sum      = w_acc_x;
    w_res_pre      = w_a_x;
    w_acc_we       = 1'b0;
    w_res_from_acc = 1'b0;
    case (s1_opc_q)
      OPC_W'(K_OP_NOP): w_res_pre = w_a_x;
      OPC_W'(K_OP_ADD): w_res_pre = w_a_x + w_b_x;
      OPC_W'(K_OP_SUB): w_res_pre = w_a_x - w_b_x;
      OPC_W'(K_OP_MUL): w_res_pre = w_p_x;
      OPC_W'(K_OP_MAC): begin
        w_acc_sum      = w_acc_x + w_p_x;
        w_acc_we       = 1'b1;
        w_res_from_acc = 1'b1;
      end
      OPC_W'(K_OP_MSU): begin
        w_acc_sum      = w_acc_x - w_p_x;
        w_acc_we       = 1'b1;
        w_res_from_acc = 1'b1;
      end
      OPC_W'(K_OP_CLRACC): begin
        w_acc_sum      = '0;
        w_acc_we       = 1'b1;
        w_res_from_acc = 1'b1;
      end
      OPC_W'(K_OP_RDACC): w_res_from_acc = 1'b1;
      default: w_res_pre = '0;
    endcase
  end

  // RDACC passes the untouched acc through w_acc_sum, so the acc path covers it too.
  assign w_res_src = w_res_from_acc ? W'($signed(w_acc_new)) : w_res_pre;

`ifdef K_DSP_SAT_EN
  k_dsp_sat #(.IN_W(W), .OUT_W(ACC_W)) u_sat_acc (
    .din  (w_acc_sum),
    .dout (w_acc_new),
    .sat  (w_acc_sat)
  );

  k_dsp_sat #(.IN_W(W), .OUT_W(DATA_W)) u_sat_res (
    .din  (w_res_src),
    .dout (w_res_val),
    .sat  (w_res_sat)
  );

  assign w_sat = !w_illegal && (w_res_sat || (w_acc_we && w_acc_sat));
`else
  logic w_unused_hi;
  assign w_acc_new   = w_acc_sum[ACC_W-1:0];
  assign w_res_val   = w_res_src[DATA_W-1:0];
  assign w_acc_sat   = 1'b0;
  assign w_res_sat   = 1'b0;
  assign w_sat       = 1'b0;
  assign w_unused_hi = ^{w_acc_sum[W-1:ACC_W], w_res_src[W-1:DATA_W], w_acc_sat, w_res_sat};
`endif

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_opc_d    = s1_opc_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_err_d    = s2_err_q;
    s2_sat_d    = s2_sat_q;
    acc_d       = acc_q;
    if (w_advance1) s1_valid_d = 1'b0;
    if (w_accept) begin
      s1_valid_d = 1'b1;
      s1_opc_d   = in_opcode;
      s1_a_d     = rs1;
      s1_b_d     = rs2;
    end
    if (w_advance2) s2_valid_d = s1_valid_q;
    // The accumulator only moves with the op leaving S1, keeping back-to-back MACs ordered.
    if (w_advance1) begin
      s2_result_d = w_illegal ? '0 : w_res_val;
      s2_err_d    = w_illegal;
      s2_sat_d    = w_sat;
      if (w_acc_we && !w_illegal) acc_d = w_acc_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_opc_q    <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_err_q    <= 1'b0;
      s2_sat_q    <= 1'b0;
      acc_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_opc_q    <= s1_opc_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_err_q    <= s2_err_d;
      s2_sat_q    <= s2_sat_d;
      acc_q       <= acc_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = s2_result_q;
  assign out_err    = s2_err_q;
  assign out_sat    = s2_sat_q;

endmodule

`default_nettype wire

// File: tb/tb_k_dsp_execute.sv
// ============================================================================
// Module : tb_k_dsp_execute
// Brief  : Directed self-checking bench for k_dsp_execute (both K_DSP_SAT_EN builds).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_k_dsp_execute;

  localparam logic [3:0] OP_NOP = 4'd0, OP_ADD = 4'd1, OP_MUL = 4'd3, OP_MAC = 4'd4;
  localparam logic [3:0] OP_CLR = 4'd6, OP_RDACC = 4'd7, OP_BAD = 4'hF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic [31:0] rs1, rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic        out_sat;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  logic [31:0] obs_res[$];
  bit          obs_err[$];
  bit          obs_sat[$];
  int          obs_cyc[$];

  k_dsp_execute #(.DATA_W(32), .ACC_W(40), .OPC_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .rs1        (rs1),
    .rs2        (rs2),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_err    (out_err),
    .out_sat    (out_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // A result seen valid&&ready at the negedge transfers on the following posedge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      obs_res.push_back(out_result);
      obs_err.push_back(out_err);
      obs_sat.push_back(out_sat);
      obs_cyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] opc, input logic [31:0] a, input logic [31:0] b,
                       output int acc_cyc);
    int  t    = 0;
    bit  done = 1'b0;
    acc_cyc   = -1;
    in_valid  = 1'b1;
    in_opcode = opc;
    rs1       = a;
    rs2       = b;
    while (!done && t < 50) begin
      @(negedge clk);
      if (in_ready) begin
        done    = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!done) check_eq("issue_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_results(input int n);
    int t = 0;
    while (obs_res.size() < n && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check_eq("result_count", 64'(obs_res.size() >= n), 64'd1);
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] r, input bit e, input bit s);
    if (obs_res.size() == 0) begin
      check_eq({tag, "_missing"}, 64'd0, 64'd1);
      return;
    end
    check_eq({tag, "_res"}, 64'(obs_res.pop_front()), 64'(r));
    check_eq({tag, "_err"}, 64'(obs_err.pop_front()), 64'(e));
    check_eq({tag, "_sat"}, 64'(obs_sat.pop_front()), 64'(s));
    void'(obs_cyc.pop_front());
  endtask

  logic [31:0] vals [4];
  int c0, c;
  int n_acc, idx;

  initial begin
    vals      = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = '0;
    rs1       = '0;
    rs2       = '0;
    out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_result", 64'(out_result), 64'd0);
    check_eq("rst_out_err", 64'(out_err), 64'd0);
    check_eq("rst_out_sat", 64'(out_sat), 64'd0);
    rst_n = 1'b1;
    idle(1);
    check_eq("rst_in_ready", 64'(in_ready), 64'd1);

    // Test 1: signed overflow on ADD
    issue(OP_ADD, 32'h7FFFFFFF, 32'h00000001, c);
    wait_results(1);
`ifdef K_DSP_SAT_EN
    pop_chk("t1_add_ovf", 32'h7FFFFFFF, 1'b0, 1'b1);
`else
    pop_chk("t1_add_ovf", 32'h80000000, 1'b0, 1'b0);
`endif

    // Test 2: back-to-back accumulator chain
    issue(OP_CLR, 32'h0, 32'h0, c0);
    issue(OP_MAC, 32'd3, 32'd4, c);
    issue(OP_MAC, 32'hFFFFFFFE, 32'd5, c);
    issue(OP_RDACC, 32'h0, 32'h0, c);
    wait_results(4);
    if (obs_cyc.size() >= 4) begin
      check_eq("t2_latency", 64'(obs_cyc[0] - c0), 64'd2);
      for (int i = 1; i < 4; i++) check_eq("t2_gap", 64'(obs_cyc[i] - obs_cyc[i-1]), 64'd1);
    end
    pop_chk("t2_clr", 32'd0, 1'b0, 1'b0);
    pop_chk("t2_mac1", 32'd12, 1'b0, 1'b0);
    pop_chk("t2_mac2", 32'd2, 1'b0, 1'b0);
    pop_chk("t2_rdacc", 32'd2, 1'b0, 1'b0);

    // Test 3: -32768 * -32768
    issue(OP_MUL, 32'h00008000, 32'h00008000, c);
    wait_results(1);
    pop_chk("t3_mul", 32'h40000000, 1'b0, 1'b0);

    // Test 4: output stall with 4 ops offered
    out_ready = 1'b0;
    n_acc     = 0;
    idx       = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid  = 1'b1;
      in_opcode = OP_NOP;
      rs1       = vals[idx];
      rs2       = '0;
      @(negedge clk);
      if (in_ready) begin
        n_acc++;
        if (idx < 3) idx++;
      end
      if (k >= 3) check_eq("t4_hold", 64'(out_result), 64'h11);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("t4_accepted", 64'(n_acc), 64'd2);
    @(negedge clk);
    check_eq("t4_in_ready", 64'(in_ready), 64'd0);
    check_eq("t4_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = idx; k < 4; k++) issue(OP_NOP, vals[k], 32'h0, c);
    wait_results(4);
    pop_chk("t4_r0", 32'h11, 1'b0, 1'b0);
    pop_chk("t4_r1", 32'h22, 1'b0, 1'b0);
    pop_chk("t4_r2", 32'h33, 1'b0, 1'b0);
    pop_chk("t4_r3", 32'h44, 1'b0, 1'b0);
    idle(5);
    check_eq("t4_no_dup", 64'(obs_res.size()), 64'd0);

    // Test 5: illegal opcode leaves acc alone
    issue(OP_CLR, 32'h0, 32'h0, c);
    issue(OP_MAC, 32'd3, 32'd4, c);
    issue(OP_BAD, 32'h1234, 32'h5678, c);
    issue(OP_RDACC, 32'h0, 32'h0, c);
    wait_results(4);
    pop_chk("t5_clr", 32'd0, 1'b0, 1'b0);
    pop_chk("t5_mac", 32'd12, 1'b0, 1'b0);
    pop_chk("t5_bad", 32'd0, 1'b1, 1'b0);
    pop_chk("t5_rdacc", 32'd12, 1'b0, 1'b0);

    // Test 6: async reset with a result held in S2
    out_ready = 1'b0;
    issue(OP_NOP, 32'h55, 32'h0, c);
    idle(2);
    @(negedge clk);
    check_eq("t6_pre_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(1);
    issue(OP_RDACC, 32'h0, 32'h0, c);
    wait_results(1);
    pop_chk("t6_rdacc", 32'd0, 1'b0, 1'b0);

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
